gemm_stream_ctrl: RTL and testbench



---
 rtl/gemm_stream_pkg.sv | 12 +
 rtl/gemm_stream_ctrl.sv | 178 +++++++++++++++++
 tb/tb_gemm_stream_ctrl.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gemm_stream_pkg.sv
// Command encoding shared between the stream controller and the GEMM array.
// Latency: n/a (types only).
// Backpressure: n/a.
package gemm_stream_pkg;

    typedef enum logic [1:0] {
        CMD_NONE          = 2'd0,
        CMD_WRITE_WEIGHTS = 2'd1,
        CMD_STREAM        = 2'd2
    } command_t;

endpackage

// File: rtl/gemm_stream_ctrl.sv
// Sequences one GEMM job: weight write, N activation rows streamed, 2*SA_SIZE-1 zero flush rows.
// Latency: first result valid 2*SA_SIZE stream cycles after the first accepted row; one row/cycle steady state.
// Backpressure: out_valid && !out_ready freezes the array (CMD_NONE) and drops in_ready until the row is taken.
module gemm_stream_ctrl
    import gemm_stream_pkg::*;
#(
    parameter int SA_SIZE         = 4,
    parameter int ACTIVATION_SIZE = 8,
    parameter int WEIGHT_SIZE     = 8,
    parameter int ROW_CNT_W       = 16
) (
    input  logic                                                  clk,
    input  logic                                                  resetn,
    input  logic                                                  start,
    input  logic [ROW_CNT_W-1:0]                                  num_rows,
    input  logic [SA_SIZE*SA_SIZE*WEIGHT_SIZE-1:0]                w_data,
    input  logic                                                  in_valid,
    output logic                                                  in_ready,
    input  logic [SA_SIZE*ACTIVATION_SIZE-1:0]                    in_data,
    output logic                                                  out_valid,
    input  logic                                                  out_ready,
    output logic [SA_SIZE*ACTIVATION_SIZE-1:0]                    out_data,
    output logic                                                  out_last,
    output logic                                                  busy,
    output logic                                                  done,
    output command_t                                              gemm_cmd,
    output logic [SA_SIZE-1:0][SA_SIZE-1:0][WEIGHT_SIZE-1:0]      gemm_weights,
    output logic [SA_SIZE-1:0][ACTIVATION_SIZE-1:0]               gemm_act_in,
    input  logic [SA_SIZE-1:0][ACTIVATION_SIZE-1:0]               gemm_act_out
);

    // Stream index of the first cycle whose edge produces a result row.
    localparam int F  = 2*SA_SIZE-1;
    // Stream counter is one bit wider so N+F never wraps for N up to 2^ROW_CNT_W-1.
    localparam int SW = ROW_CNT_W+1;
    localparam logic [SW-1:0] F_S = SW'(F);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_W = 3'd1,
        STREAM = 3'd2,
        FLUSH  = 3'd3,
        DRAIN  = 3'd4
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [ROW_CNT_W-1:0]   n_rows;
    logic [ROW_CNT_W-1:0]   in_cnt;
    logic [ROW_CNT_W-1:0]   out_cnt;
    logic [SW-1:0]          s_cnt;
    logic                   stall;
    logic                   in_fire;
    logic                   stream_fire;
    logic                   out_fire;
    logic                   job_start;

    assign stall     = out_valid && !out_ready;
    assign out_fire  = out_valid && out_ready;
    assign out_data  = gemm_act_out;
    assign out_last  = out_valid && (out_cnt == n_rows - 1'b1);
    assign busy      = (state != IDLE);
    assign job_start = (state == IDLE) && start && (num_rows != '0);

    // Next-state and GEMM command decode; the array only advances on CMD_STREAM.
    always_comb begin
        state_nxt   = state;
        gemm_cmd    = CMD_NONE;
        gemm_act_in = '0;
        in_ready    = 1'b0;
        in_fire     = 1'b0;
        stream_fire = 1'b0;
        case (state)
            IDLE: begin
                if (job_start) begin
                    state_nxt = LOAD_W;
                end
            end
            LOAD_W: begin
                gemm_cmd  = CMD_WRITE_WEIGHTS;
                state_nxt = STREAM;
            end
            STREAM: begin
                in_ready = !stall;
                if (in_valid && !stall) begin
                    in_fire     = 1'b1;
                    stream_fire = 1'b1;
                    gemm_cmd    = CMD_STREAM;
                    gemm_act_in = in_data;
                    if (in_cnt == n_rows - 1'b1) begin
                        state_nxt = FLUSH;
                    end
                end
            end
            FLUSH: begin
                if (!stall) begin
                    stream_fire = 1'b1;
                    gemm_cmd    = CMD_STREAM;
                    if (s_cnt == {1'b0, n_rows} + F_S - SW'(1)) begin
                        state_nxt = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (done) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Job parameters captured at start: row count and the weight matrix held on the GEMM port.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            n_rows       <= '0;
            gemm_weights <= '0;
        end else if (job_start) begin
            n_rows       <= num_rows;
            gemm_weights <= w_data;
        end
    end

    // Input-row, stream-cycle and output-row counters, cleared for each new job.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            in_cnt  <= '0;
            out_cnt <= '0;
            s_cnt   <= '0;
        end else if (job_start) begin
            in_cnt  <= '0;
            out_cnt <= '0;
            s_cnt   <= '0;
        end else begin
            if (in_fire) begin
                in_cnt <= in_cnt + 1'b1;
            end
            if (stream_fire) begin
                s_cnt <= s_cnt + 1'b1;
            end
            if (out_fire) begin
                out_cnt <= out_cnt + 1'b1;
            end
        end
    end

    // Result valid: a qualifying stream cycle presents a new row, which wins over a same-cycle handshake.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            out_valid <= 1'b0;
        end else if (stream_fire && (s_cnt >= F_S)) begin
            out_valid <= 1'b1;
        end else if (out_fire) begin
            out_valid <= 1'b0;
        end
    end

    // Completion pulse one cycle after the final result is taken; DRAIN holds busy through it.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            done <= 1'b0;
        end else begin
            done <= (state == DRAIN) && out_fire;
        end
    end

endmodule

// File: tb/tb_gemm_stream_ctrl.sv
// Bench for gemm_stream_ctrl with a behavioural GEMM array attached to its command ports.
// Latency: n/a.
// Backpressure: out_ready driven randomly, held low, or always high depending on the job.
`timescale 1ns/1ps
module tb_gemm_stream_ctrl;
    import gemm_stream_pkg::*;

    localparam int SA = 4;
    localparam int AW = 8;
    localparam int WW = 8;
    localparam int CW = 16;
    localparam int F  = 2*SA-1;

    logic                         clk = 1'b0;
    logic                         resetn;
    logic                         start;
    logic [CW-1:0]                num_rows;
    logic [SA*SA*WW-1:0]          w_data;
    logic                         in_valid;
    logic                         in_ready;
    logic [SA*AW-1:0]             in_data;
    logic                         out_valid;
    logic                         out_ready;
    logic [SA*AW-1:0]             out_data;
    logic                         out_last;
    logic                         busy;
    logic                         done;
    command_t                     gemm_cmd;
    logic [SA-1:0][SA-1:0][WW-1:0] gemm_weights;
    logic [SA-1:0][AW-1:0]        gemm_act_in;
    logic [SA-1:0][AW-1:0]        gemm_act_out;

    int checks = 0;
    int errors = 0;

    logic [31:0] job_rows [0:7];
    logic [31:0] job_exp  [0:7];

    typedef struct packed {
        logic [31:0] in_row;
        logic [31:0] exp_row;
    } vec_t;
    vec_t tbl [0:4];

    always #5 clk = ~clk;

    gemm_stream_ctrl #(
        .SA_SIZE(SA), .ACTIVATION_SIZE(AW), .WEIGHT_SIZE(WW), .ROW_CNT_W(CW)
    ) dut (
        .clk(clk), .resetn(resetn), .start(start), .num_rows(num_rows), .w_data(w_data),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .busy(busy), .done(done), .gemm_cmd(gemm_cmd), .gemm_weights(gemm_weights),
        .gemm_act_in(gemm_act_in), .gemm_act_out(gemm_act_out)
    );

    // O[c] = sum_r I[r] * W[r][c] mod 256, W[r][c] at bits (r*SA+c)*WW.
    function automatic logic [31:0] mat_row(input logic [127:0] w, input logic [31:0] row);
        logic [31:0] res;
        logic [7:0]  acc;
        logic [15:0] prod;
        res = '0;
        for (int c = 0; c < SA; c++) begin
            acc = '0;
            for (int r = 0; r < SA; r++) begin
                prod = row[r*AW +: AW] * w[(r*SA+c)*WW +: WW];
                acc  = acc + prod[7:0];
            end
            res[c*AW +: AW] = acc;
        end
        return res;
    endfunction

    // Behavioural array: each STREAM cycle shifts a row in; output is the row entered F stream cycles earlier.
    logic [31:0]  hist [0:F];
    logic [127:0] wq;
    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wq <= '0;
            for (int i = 0; i <= F; i++) hist[i] <= '0;
        end else begin
            if (gemm_cmd == CMD_WRITE_WEIGHTS) wq <= gemm_weights;
            if (gemm_cmd == CMD_STREAM) begin
                hist[0] <= gemm_act_in;
                for (int i = 1; i <= F; i++) hist[i] <= hist[i-1];
            end
        end
    end
    assign gemm_act_out = mat_row(wq, hist[F]);

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic run_job(input string tag, input int n, input logic [127:0] w, input int gap_pct,
                           input int rdy_pct, input bit hold_mode, input bit timing, input bit poke);
        int cyc = 0, sent = 0, got = 0, ww = 0, str = 0, dones = 0;
        int str_first = -1, str_last = -1, ww_cyc = -1, first_acc = -1, first_ov = -1;
        int first_hs = -1, last_hs = -1, done_cyc = -1, hold_left = 0;
        int v_rdy = 0, v_str = 0, v_stab = 0;
        bit hold_started = 0, finished = 0, prev_stall = 0, stall;
        logic [31:0] prev_data = '0;
        @(negedge clk);
        start = 1'b1; num_rows = CW'(n); w_data = w; in_valid = 1'b0; out_ready = 1'b1;
        while (!finished && cyc < 400) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            if (poke && cyc == 4) begin
                start = 1'b1; num_rows = 16'd3; w_data = {$urandom, $urandom, $urandom, $urandom};
            end
            if (hold_mode && !hold_started && out_valid) begin
                hold_started = 1'b1; hold_left = 20;
            end
            if (hold_left > 0) begin
                out_ready = 1'b0; hold_left--;
            end else begin
                out_ready = ($urandom_range(99) < rdy_pct);
            end
            in_valid = (sent < n) && ($urandom_range(99) >= gap_pct);
            in_data  = (sent < n) ? job_rows[sent] : 32'hDEADBEEF;
            #1;
            if (gemm_cmd == CMD_WRITE_WEIGHTS) begin ww++; ww_cyc = cyc; end
            if (gemm_cmd == CMD_STREAM) begin
                str++;
                if (str_first < 0) str_first = cyc;
                str_last = cyc;
            end
            stall = out_valid && !out_ready;
            if (stall && in_ready) v_rdy++;
            if (stall && gemm_cmd == CMD_STREAM) v_str++;
            if (prev_stall && stall && out_data !== prev_data) v_stab++;
            if (in_valid && in_ready) begin
                if (sent == 0) first_acc = cyc;
                sent++;
            end
            if (out_valid && first_ov < 0) first_ov = cyc;
            if (out_valid && out_ready) begin
                if (got < n) begin
                    chk({tag, "_data"}, out_data, job_exp[got]);
                    chk({tag, "_last"}, out_last, (got == n-1));
                end
                if (first_hs < 0) first_hs = cyc;
                last_hs = cyc;
                got++;
            end
            if (done) begin
                dones++;
                done_cyc = cyc;
                chk({tag, "_busy_at_done"}, busy, 1);
            end else if (done_cyc >= 0 && cyc == done_cyc + 1) begin
                chk({tag, "_busy_after_done"}, busy, 0);
                finished = 1'b1;
            end
            prev_stall = stall;
            prev_data  = out_data;
        end
        in_valid = 1'b0; out_ready = 1'b1; start = 1'b0;
        chk({tag, "_timeout"}, finished, 1);
        chk({tag, "_ww_count"}, ww, 1);
        chk({tag, "_stream_count"}, str, n + F);
        chk({tag, "_result_count"}, got, n);
        chk({tag, "_done_count"}, dones, 1);
        chk({tag, "_rdy_while_stall"}, v_rdy, 0);
        chk({tag, "_stream_while_stall"}, v_str, 0);
        chk({tag, "_stable_while_stall"}, v_stab, 0);
        if (timing) begin
            chk({tag, "_stream_consecutive"}, str_last - str_first + 1, n + F);
            chk({tag, "_ww_before_stream"}, ww_cyc, str_first - 1);
            chk({tag, "_first_out_latency"}, first_ov - first_acc, F + 1);
        end
        if (hold_mode) begin
            chk({tag, "_back_to_back"}, last_hs - first_hs, n - 1);
        end
    endtask

    task automatic rand_job_data(input int n, output logic [127:0] w);
        w = {$urandom, $urandom, $urandom, $urandom};
        for (int i = 0; i < n; i++) begin
            job_rows[i] = $urandom;
            job_exp[i]  = mat_row(w, job_rows[i]);
        end
    endtask

    initial begin
        logic [127:0] w;
        int acc, k, bad;

        tbl[0] = '{32'h04030201, 32'h10090401};
        tbl[1] = '{32'h08070605, 32'h20150C05};
        tbl[2] = '{32'h0C0B0A09, 32'h30211409};
        tbl[3] = '{32'h100F0E0D, 32'h402D1C0D};
        tbl[4] = '{32'h14131211, 32'h50392411};

        resetn = 1'b0; start = 1'b0; num_rows = '0; w_data = '0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        #1;
        chk("rst_cmd", gemm_cmd, CMD_NONE);
        chk("rst_weights", gemm_weights, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        repeat (2) @(negedge clk);
        resetn = 1'b1;

        // Directed diag(1,2,3,4) job from the vector table.
        w = '0;
        w[0 +: 8] = 8'd1; w[40 +: 8] = 8'd2; w[80 +: 8] = 8'd3; w[120 +: 8] = 8'd4;
        for (int i = 0; i < 5; i++) begin
            job_rows[i] = tbl[i].in_row;
            job_exp[i]  = tbl[i].exp_row;
        end
        run_job("diag", 5, w, 0, 100, 1'b0, 1'b1, 1'b0);

        // Random weights and rows with random backpressure and input gaps.
        for (int j = 0; j < 3; j++) begin
            rand_job_data(5, w);
            run_job("rand", 5, w, 20, 50, 1'b0, 1'b0, 1'b0);
        end

        // Single row with gappy input.
        rand_job_data(1, w);
        run_job("n1", 1, w, 50, 100, 1'b0, 1'b0, 1'b0);

        // start with num_rows == 0 in IDLE is ignored.
        @(negedge clk);
        start = 1'b1; num_rows = '0; w_data = {$urandom, $urandom, $urandom, $urandom};
        @(negedge clk);
        start = 1'b0;
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            #1;
            if (busy || gemm_cmd != CMD_NONE) bad++;
            @(negedge clk);
        end
        chk("zero_start_ignored", bad, 0);

        // start pulsed mid-job is ignored.
        rand_job_data(5, w);
        run_job("poke", 5, w, 0, 100, 1'b0, 1'b0, 1'b1);

        // Reset asserted while flushing aborts the job.
        rand_job_data(3, w);
        @(negedge clk);
        start = 1'b1; num_rows = 16'd3; w_data = w;
        acc = 0; k = 0;
        while (acc < 3 && k < 30) begin
            @(negedge clk);
            start = 1'b0; k++;
            in_valid = 1'b1; in_data = job_rows[acc];
            #1;
            if (in_ready) acc++;
        end
        chk("flushrst_accepted", acc, 3);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk("flush_in_ready", in_ready, 0);
        chk("flush_cmd", gemm_cmd, CMD_STREAM);
        resetn = 1'b0;
        #1;
        chk("abort_cmd", gemm_cmd, CMD_NONE);
        chk("abort_weights", gemm_weights, 0);
        chk("abort_busy", busy, 0);
        chk("abort_out_valid", out_valid, 0);
        chk("abort_in_ready", in_ready, 0);
        chk("abort_done", done, 0);
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        bad = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            #1;
            if (out_valid || busy || done) bad++;
        end
        chk("abort_no_partial", bad, 0);
        rand_job_data(2, w);
        run_job("post_rst", 2, w, 0, 100, 1'b0, 1'b0, 1'b0);

        // Long stall at the first result, then full-rate drain.
        rand_job_data(5, w);
        run_job("hold", 5, w, 0, 100, 1'b1, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
